mod_timer_ctrl: RTL and testbench
=================================

MOD_TIMER_CTRL -- requirements
Module: mod_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of period register and count output.
REQ-002 SHALL have parameter N_DEF, default 10: period loaded at reset.
REQ-003 SHALL have parameter REP_W, default 8: width of repeat-count register.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid  in  1  config offer.
REQ-007 SHALL have port cfg_ready  out  1  config accept; high exactly when state==IDLE.
REQ-008 SHALL have port cfg_period  in  WIDTH  modulus P; 0 is treated as 1.
REQ-009 SHALL have port cfg_reps  in  REP_W  wraps before completion; 0 = run forever.
REQ-010 SHALL have port start  in  1  one-cycle request to begin counting.
REQ-011 SHALL have port stop  in  1  one-cycle abort request.
REQ-012 SHALL have port pause  in  1  level; freezes counting while high.
REQ-013 SHALL have port irq_ack  in  1  clears done.
REQ-014 SHALL have port count  out  WIDTH  current count, registered.
REQ-015 SHALL have port tick  out  1  registered one-cycle pulse per wrap.
REQ-016 SHALL have port busy  out  1  high in RUN or PAUSE.
REQ-017 SHALL have port done  out  1  high in DONE.
REQ-018 SHALL have port state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-019 Config SHALL be latched (period_r, reps_r) on any edge where cfg_valid && cfg_ready; ignored otherwise.
REQ-020 IDLE + start SHALL go to RUN with count=0 and reps_left=reps_r; if cfg_valid and start coincide, the newly latched config SHALL be used.
REQ-021 In RUN, count SHALL increment by 1 per cycle; when count==period_r-1 it SHALL wrap to 0 on the next edge (mod-period_r, never exceeding period_r-1).
REQ-022 With period_r==1, count SHALL stay 0 and a wrap SHALL occur every RUN cycle.
REQ-023 tick SHALL be 1 in the cycle after each wrap edge (coincident with count==0 following the wrap), else 0.
REQ-024 On each wrap with reps_r!=0, reps_left SHALL decrement; the wrap with reps_left==1 SHALL move to DONE (count=0, tick=1 that cycle).
REQ-025 With reps_r==0, RUN SHALL continue indefinitely; reps_left unused.
REQ-026 RUN with pause high SHALL go to PAUSE with count held; PAUSE with pause low SHALL return to RUN and resume from the held count (no lost or extra counts).
REQ-027 stop in RUN or PAUSE SHALL go to IDLE, count=0, no tick, done stays 0.
REQ-028 Priority within RUN: stop > pause > count/wrap; a wrap is not taken on the edge stop or pause is sampled.
REQ-029 start SHALL be ignored outside IDLE; stop and pause SHALL be ignored in IDLE and DONE.
REQ-030 DONE SHALL hold (count=0, done=1) until irq_ack, then go to IDLE; start coinciding with irq_ack SHALL be ignored.
REQ-031 start and stop together in IDLE SHALL leave the block in IDLE.

Reset
REQ-032 rst low SHALL immediately (asynchronously) force state=IDLE, count=0, tick=0, busy=0, done=0, cfg_ready=1, period_r=N_DEF, reps_r=0, reps_left=0.
REQ-033 Reset asserted mid-RUN or mid-PAUSE SHALL abort with no tick or done pulse; release SHALL leave the block in IDLE awaiting start.

Verification
REQ-034 Reset release, start without config -> count 0..9 repeating, tick each cycle count returns to 0, busy=1, never done.
REQ-035 cfg P=4, reps=3, start -> exactly 3 ticks, 12 counting cycles, then state=3, done=1 until irq_ack; irq_ack -> state=0 next cycle.
REQ-036 P=5 reps=0, pause high at count=2 for 7 cycles -> state=2, count held at 2; release -> 3,4,0 with tick at 0.
REQ-037 P=6, stop at count=3 -> state=0, count=0, no tick, done=0; start again -> counts from 0.
REQ-038 cfg P=0 reps=2 with start same cycle -> treated as P=1: ticks on 2 consecutive cycles then DONE; cfg_valid while RUN -> cfg_ready=0, config unchanged.
REQ-039 rst low asynchronously at count=7 of P=10 -> all outputs at reset values before next clk edge; start/irq_ack during reset ignored.

Source files
------------

// File: rtl/mod_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod_timer_ctrl
// Description : Modulo-P timer with handshaked config, pause/stop control,
//               wrap tick and repeat-count completion (DONE until irq_ack).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_timer_ctrl #(
    parameter int WIDTH = 4,
    parameter int N_DEF = 10,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_PERIOD_RST = (N_DEF == 0) ? WIDTH'(1) : WIDTH'(N_DEF);

    state_t           r_state,     w_state;
    logic [WIDTH-1:0] r_count,     w_count;
    logic             r_tick,      w_tick;
    logic [WIDTH-1:0] r_period,    w_period;
    logic [REP_W-1:0] r_reps,      w_reps;
    logic [REP_W-1:0] r_reps_left, w_reps_left;
    logic             w_cfg_take;
    logic             w_last;

    always_comb begin
        w_cfg_take  = cfg_valid && (r_state == S_IDLE);
        w_last      = (r_count == (r_period - WIDTH'(1)));
        w_state     = r_state;
        w_count     = r_count;
        w_tick      = 1'b0;
        w_reps_left = r_reps_left;
        // A zero period is stored as 1 so the wrap compare never underflows.
        w_period    = w_cfg_take ? ((cfg_period == '0) ? WIDTH'(1) : cfg_period) : r_period;
        w_reps      = w_cfg_take ? cfg_reps : r_reps;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state     = S_RUN;
                    w_count     = '0;
                    w_reps_left = w_reps;
                end
            end
            S_RUN, S_PAUSE: begin
                if (stop) begin
                    w_state = S_IDLE;
                    w_count = '0;
                end else if (pause) begin
                    w_state = S_PAUSE;
                end else begin
                    w_state = S_RUN;
                    if (w_last) begin
                        w_count = '0;
                        w_tick  = 1'b1;
                        if (r_reps != '0) begin
                            w_reps_left = r_reps_left - REP_W'(1);
                            if (r_reps_left == REP_W'(1)) begin
                                w_state = S_DONE;
                            end
                        end
                    end else begin
                        w_count = r_count + WIDTH'(1);
                    end
                end
            end
            S_DONE: begin
                w_count = '0;
                if (irq_ack) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_tick      <= 1'b0;
            r_period    <= c_PERIOD_RST;
            r_reps      <= '0;
            r_reps_left <= '0;
        end else begin
            r_state     <= w_state;
            r_count     <= w_count;
            r_tick      <= w_tick;
            r_period    <= w_period;
            r_reps      <= w_reps;
            r_reps_left <= w_reps_left;
        end
    end

    assign cfg_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign done      = (r_state == S_DONE);
    assign state     = r_state;
    assign count     = r_count;
    assign tick      = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_mod_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_timer_ctrl
// Description : Self-checking bench: vector table, directed corner sequences
//               and random stimulus against a behavioural timer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_timer_ctrl;

    localparam int WIDTH = 4;
    localparam int N_DEF = 10;
    localparam int REP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid, cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic [REP_W-1:0] cfg_reps;
    logic             start, stop, pause, irq_ack;
    logic [WIDTH-1:0] count;
    logic             tick, busy, done;
    logic [1:0]       state;

    always #5 clk = ~clk;

    mod_timer_ctrl #(.WIDTH(WIDTH), .N_DEF(N_DEF), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_reps(cfg_reps), .start(start), .stop(stop),
        .pause(pause), .irq_ack(irq_ack), .count(count), .tick(tick),
        .busy(busy), .done(done), .state(state)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 idle, 1 run, 2 paused, 3 done.
    int m_st, m_cnt, m_per, m_reps, m_left;
    bit m_tick;

    typedef struct packed {
        logic       cv;
        logic [3:0] p;
        logic [7:0] r;
        logic       st, sp, pa, ack;
        logic [1:0] e_state;
        logic [3:0] e_cnt;
        logic       e_tick;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic cv, logic [3:0] p, logic [7:0] r, logic st, logic sp,
                                logic pa, logic ack, logic [1:0] es, logic [3:0] ec, logic et);
        vec_t v;
        v.cv = cv; v.p = p; v.r = r; v.st = st; v.sp = sp; v.pa = pa; v.ack = ack;
        v.e_state = es; v.e_cnt = ec; v.e_tick = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({state, count, tick, busy, done, cfg_ready});
    endfunction

    function automatic logic [31:0] model_vec();
        return 32'({2'(m_st), WIDTH'(m_cnt), m_tick, (m_st == 1 || m_st == 2), (m_st == 3), (m_st == 0)});
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_per = N_DEF; m_reps = 0; m_left = 0; m_tick = 0;
    endtask

    task automatic model_step();
        bit acc;
        int per_n, reps_n;
        acc    = cfg_valid && (m_st == 0);
        per_n  = acc ? ((cfg_period == 0) ? 1 : int'(cfg_period)) : m_per;
        reps_n = acc ? int'(cfg_reps) : m_reps;
        m_tick = 0;
        case (m_st)
            0: if (start && !stop) begin m_st = 1; m_cnt = 0; m_left = reps_n; end
            1, 2: begin
                if (stop) begin
                    m_st = 0; m_cnt = 0;
                end else if (pause) begin
                    m_st = 2;
                end else begin
                    m_st  = 1;
                    m_cnt = (m_cnt + 1) % m_per;
                    if (m_cnt == 0) begin
                        m_tick = 1;
                        if (m_reps != 0) begin
                            m_left--;
                            if (m_left == 0) m_st = 3;
                        end
                    end
                end
            end
            default: if (irq_ack) m_st = 0;
        endcase
        m_per  = per_n;
        m_reps = reps_n;
    endtask

    task automatic cycle(input string name);
        @(posedge clk);
        if (rst) model_step(); else model_reset();
        #1;
        check(name, dut_vec(), model_vec());
    endtask

    task automatic drive(input logic cv, input logic [3:0] p, input logic [7:0] r,
                         input logic st, input logic sp, input logic pa, input logic ack);
        cfg_valid = cv; cfg_period = p; cfg_reps = r;
        start = st; stop = sp; pause = pa; irq_ack = ack;
    endtask

    task automatic idle_in();
        drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges, checks outputs before the next edge, releases later.
    task automatic async_reset(input string name, input int edges);
        #3;
        rst = 1'b0;
        start = 1'b1;
        irq_ack = 1'b1;
        model_reset();
        #1;
        check(name, dut_vec(), 32'({2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        for (int i = 0; i < edges; i++) cycle({name, "_held"});
        #3;
        rst = 1'b1;
        idle_in();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(1, 4'd4, 8'd3, 1, 0, 0, 0, 2'd1, 4'd0, 0);
        tbl[1]  = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd1, 0);
        tbl[2]  = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd2, 0);
        tbl[3]  = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd3, 0);
        tbl[4]  = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd0, 1);
        tbl[5]  = mk(0, 4'd0, 8'd0, 1, 0, 0, 0, 2'd1, 4'd1, 0);
        tbl[6]  = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd2, 0);
        tbl[7]  = mk(1, 4'd9, 8'd9, 0, 0, 0, 0, 2'd1, 4'd3, 0);
        tbl[8]  = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd0, 1);
        tbl[9]  = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd1, 0);
        tbl[10] = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd2, 0);
        tbl[11] = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd1, 4'd3, 0);
        tbl[12] = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd3, 4'd0, 1);
        tbl[13] = mk(0, 4'd0, 8'd0, 1, 1, 1, 0, 2'd3, 4'd0, 0);
        tbl[14] = mk(0, 4'd0, 8'd0, 0, 0, 0, 0, 2'd3, 4'd0, 0);
        tbl[15] = mk(0, 4'd0, 8'd0, 1, 0, 0, 1, 2'd0, 4'd0, 0);
        tbl[16] = mk(0, 4'd0, 8'd0, 1, 1, 0, 0, 2'd0, 4'd0, 0);
        tbl[17] = mk(0, 4'd0, 8'd0, 0, 0, 1, 0, 2'd0, 4'd0, 0);

        idle_in();
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check("reset_outputs", dut_vec(), 32'({2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        repeat (2) @(posedge clk);
        #1 check("reset_held", dut_vec(), 32'({2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}));
        #2 rst = 1'b1;

        // Default period after reset, run forever.
        drive(0, 4'd0, 8'd0, 1, 0, 0, 0);
        cycle("def_start");
        check("def_start_cnt", 32'(count), 32'd0);
        idle_in();
        for (int k = 1; k <= 25; k++) begin
            cycle("def_run");
            check($sformatf("def_cnt_k%0d", k), 32'(count), 32'(k % 10));
            check($sformatf("def_tick_k%0d", k), 32'(tick), 32'(k % 10 == 0));
            check($sformatf("def_busy_k%0d", k), 32'({busy, done}), 32'b10);
        end
        stop = 1'b1;
        cycle("def_stop");
        check("def_stop_state", 32'({state, count, tick}), 32'd0);
        idle_in();

        // Vector table: P=4 reps=3 completion, DONE hold, IDLE ignores.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].cv, tbl[i].p, tbl[i].r, tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ack);
            cycle($sformatf("tbl%0d_model", i));
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].e_tick));
        end
        idle_in();

        // Pause holds count, release resumes without loss.
        drive(1, 4'd5, 8'd0, 0, 0, 0, 0);
        cycle("p5_cfg");
        drive(0, 4'd0, 8'd0, 1, 0, 0, 0);
        cycle("p5_start");
        idle_in();
        cycle("p5_c1");
        cycle("p5_c2");
        check("p5_at2", 32'(count), 32'd2);
        pause = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycle("p5_pause");
            check("p5_pause_hold", 32'({state, count, tick}), 32'({2'd2, 4'd2, 1'b0}));
        end
        pause = 1'b0;
        cycle("p5_r3");
        check("p5_resume3", 32'({state, count, tick}), 32'({2'd1, 4'd3, 1'b0}));
        cycle("p5_r4");
        check("p5_resume4", 32'({state, count, tick}), 32'({2'd1, 4'd4, 1'b0}));
        cycle("p5_r0");
        check("p5_resume0", 32'({state, count, tick}), 32'({2'd1, 4'd0, 1'b1}));
        stop = 1'b1;
        cycle("p5_stop");
        idle_in();

        // Stop mid-count, restart, config refused while running.
        drive(1, 4'd6, 8'd0, 1, 0, 0, 0);
        cycle("p6_start");
        idle_in();
        repeat (3) cycle("p6_run");
        check("p6_at3", 32'(count), 32'd3);
        stop = 1'b1;
        cycle("p6_stop");
        check("p6_stopped", 32'({state, count, tick, done}), 32'd0);
        drive(0, 4'd0, 8'd0, 1, 0, 0, 0);
        cycle("p6_restart");
        check("p6_restart_cnt", 32'({state, count}), 32'({2'd1, 4'd0}));
        drive(1, 4'd3, 8'd1, 0, 0, 0, 0);
        cycle("p6_cfg_busy");
        check("p6_cfg_ready", 32'(cfg_ready), 32'd0);
        idle_in();
        repeat (4) cycle("p6_run2");
        check("p6_keeps_period", 32'({state, count, tick}), 32'({2'd1, 4'd5, 1'b0}));
        cycle("p6_wrap");
        check("p6_wrap_tick", 32'({count, tick}), 32'({4'd0, 1'b1}));
        stop = 1'b1;
        cycle("p6_stop2");
        idle_in();

        // Zero period behaves as 1: a wrap every cycle.
        drive(1, 4'd0, 8'd2, 1, 0, 0, 0);
        cycle("p0_start");
        check("p0_start", 32'({state, count, tick}), 32'({2'd1, 4'd0, 1'b0}));
        idle_in();
        cycle("p0_w1");
        check("p0_tick1", 32'({state, count, tick}), 32'({2'd1, 4'd0, 1'b1}));
        cycle("p0_w2");
        check("p0_tick2_done", 32'({state, count, tick, done}), 32'({2'd3, 4'd0, 1'b1, 1'b1}));
        cycle("p0_hold");
        check("p0_done_hold", 32'({state, tick, done}), 32'({2'd3, 1'b0, 1'b1}));
        irq_ack = 1'b1;
        cycle("p0_ack");
        check("p0_acked", 32'(state), 32'd0);
        idle_in();

        // Asynchronous reset in the middle of a run.
        drive(1, 4'd10, 8'd0, 1, 0, 0, 0);
        cycle("r_start");
        idle_in();
        repeat (7) cycle("r_run");
        check("r_at7", 32'(count), 32'd7);
        async_reset("r_async", 2);
        cycle("r_after");
        check("r_idle", 32'({state, count, tick}), 32'd0);
        start = 1'b1;
        cycle("r_restart");
        idle_in();
        repeat (9) cycle("r_run2");
        check("r_default_period", 32'(count), 32'd9);
        stop = 1'b1;
        cycle("r_stop");

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 7)), 8'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            cycle("rand");
            if ($urandom_range(0, 399) == 0) async_reset("rand_async", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
